piso_shift_tx: RTL

Parallel-in, serial-out transmit shifter. It is the sending end that feeds our serial-in shift registers: it accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock. Direction is selectable per word, MSB-first (left) or LSB-first (right). The block sits between a parallel producer and a serial link or shift-register chain.

---
 rtl/piso_shift_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmit shifter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per shift_en cycle, MSB-first (drt=1) or LSB-first (drt=0).
// Optional macro PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             drt,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: load in idle, shift on shift_en, exit at terminal count.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          shreg_d = din;
          dir_d   = drt;
          cnt_d   = '0;
`ifdef PARITY_EN
          par_d   = ^din;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        if (shift_en) begin
          shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
`ifdef PARITY_EN
            state_d = StPar;
`else
            state_d = StIdle;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
`ifdef PARITY_EN
      StPar: begin
        if (shift_en) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registers only; no input reaches sout.
  always_comb begin
    load_ready = (state_q == StIdle);
    busy       = (state_q != StIdle);
    sout_valid = busy;
    done       = done_q;
    sout       = 1'b0;
    if (state_q == StShift) begin
      sout = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];
    end
`ifdef PARITY_EN
    if (state_q == StPar) begin
      sout = par_q;
    end
`endif
  end

endmodule
